// File: rtl/mor1kx_cfgrs_arbiter.sv
// Arbiter between the CPU and the debug unit for reads of the read-only
// configuration SPRs (group 0, index 0..10). Each access is acked one cycle after its grant.
module mor1kx_cfgrs_arbiter #(
    parameter FEATURE_DEBUGUNIT = "NONE"
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_spr_req_i,
    input  logic [15:0] cpu_spr_addr_i,
    input  logic        cpu_spr_we_i,
    output logic        cpu_spr_ack_o,
    output logic [31:0] cpu_spr_dat_o,

    input  logic        du_spr_req_i,
    input  logic [15:0] du_spr_addr_i,
    input  logic        du_spr_we_i,
    output logic        du_spr_ack_o,
    output logic [31:0] du_spr_dat_o,

    input  logic [31:0] spr_vr,
    input  logic [31:0] spr_upr,
    input  logic [31:0] spr_cpucfgr,
    input  logic [31:0] spr_dmmucfgr,
    input  logic [31:0] spr_immucfgr,
    input  logic [31:0] spr_dccfgr,
    input  logic [31:0] spr_iccfgr,
    input  logic [31:0] spr_dcfgr,
    input  logic [31:0] spr_pccfgr,
    input  logic [31:0] spr_vr2,
    input  logic [31:0] spr_avr
);

    localparam bit DU_EN = (FEATURE_DEBUGUNIT != "NONE");

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_du;
    logic        r_cpu_vld_p1;
    logic        r_du_vld_p1;
    logic [15:0] r_addr_p1;
    logic        r_we_p1;
    logic [31:0] r_rdat_p1;

    logic        w_du_req;
    logic        w_gnt_cpu;
    logic        w_gnt_du;
    logic        w_gnt_any;
    logic [15:0] w_addr_p0;
    logic        w_we_p0;
    logic        w_rsp_hit;
    logic [31:0] w_rsp_dat;

    function automatic logic [31:0] cfg_lookup(input logic [3:0] idx);
        case (idx)
            4'd0:    return spr_vr;
            4'd1:    return spr_upr;
            4'd2:    return spr_cpucfgr;
            4'd3:    return spr_dmmucfgr;
            4'd4:    return spr_immucfgr;
            4'd5:    return spr_dccfgr;
            4'd6:    return spr_iccfgr;
            4'd7:    return spr_dcfgr;
            4'd8:    return spr_pccfgr;
            4'd9:    return spr_vr2;
            4'd10:   return spr_avr;
            default: return 32'h0;
        endcase
    endfunction

    assign w_du_req  = DU_EN && du_spr_req_i;
    assign w_gnt_any = w_gnt_cpu || w_gnt_du;
    assign w_addr_p0 = w_gnt_du ? du_spr_addr_i : cpu_spr_addr_i;
    assign w_we_p0   = w_gnt_du ? du_spr_we_i : cpu_spr_we_i;

    // Contention goes to whoever was not granted last, so continuous requests alternate.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_cpu   = 1'b0;
        w_gnt_du    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_spr_req_i && w_du_req) begin
                    w_gnt_cpu = r_last_du;
                    w_gnt_du  = !r_last_du;
                end else begin
                    w_gnt_cpu = cpu_spr_req_i;
                    w_gnt_du  = w_du_req;
                end
                if (w_gnt_cpu || w_gnt_du) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_du    <= 1'b1;
            r_cpu_vld_p1 <= 1'b0;
            r_du_vld_p1  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cpu_vld_p1 <= w_gnt_cpu;
            r_du_vld_p1  <= w_gnt_du;
            if (w_gnt_any) begin
                r_last_du <= w_gnt_du;
            end
        end
    end

    // p0 -> p1: capture the granted request; later input changes cannot affect the response.
    always_ff @(posedge clk) begin
        if (w_gnt_any) begin
            r_addr_p1 <= w_addr_p0;
            r_we_p1   <= w_we_p0;
            r_rdat_p1 <= cfg_lookup(w_addr_p0[3:0]);
        end
    end

    // p1: writes and anything outside group 0 / index 0..10 read back as zero.
    assign w_rsp_hit = !r_we_p1 && (r_addr_p1[15:11] == 5'd0) &&
                       (r_addr_p1[10:4] == 7'd0) && (r_addr_p1[3:0] <= 4'd10);
    assign w_rsp_dat = w_rsp_hit ? r_rdat_p1 : 32'h0;

    assign cpu_spr_ack_o = r_cpu_vld_p1;
    assign cpu_spr_dat_o = r_cpu_vld_p1 ? w_rsp_dat : 32'h0;
    assign du_spr_ack_o  = DU_EN && r_du_vld_p1;
    assign du_spr_dat_o  = (DU_EN && r_du_vld_p1) ? w_rsp_dat : 32'h0;

endmodule

// File: tb/tb_mor1kx_cfgrs_arbiter.sv
// Bench for mor1kx_cfgrs_arbiter: a DU-enabled instance and a DU-disabled instance, driven by
// directed and random requests, checked by a scoreboard fed from a behavioural model.
module tb_mor1kx_cfgrs_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [31:0]       cfg [0:10];
    // Port index: 0 = main CPU, 1 = main DU, 2 = no-DU CPU, 3 = no-DU DU
    logic [3:0]        req;
    logic [3:0]        we;
    logic [3:0][15:0]  addr;
    wire  [3:0]        ack;
    wire  [3:0][31:0]  dat;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t q [4][$];
    int   log_port [$];
    int   log_cyc [$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   m_busy [2];
    bit   m_last_du [2];

    mor1kx_cfgrs_arbiter #(.FEATURE_DEBUGUNIT("ENABLED")) u_dut (
        .clk(clk), .rst(rst),
        .cpu_spr_req_i(req[0]), .cpu_spr_addr_i(addr[0]), .cpu_spr_we_i(we[0]),
        .cpu_spr_ack_o(ack[0]), .cpu_spr_dat_o(dat[0]),
        .du_spr_req_i(req[1]), .du_spr_addr_i(addr[1]), .du_spr_we_i(we[1]),
        .du_spr_ack_o(ack[1]), .du_spr_dat_o(dat[1]),
        .spr_vr(cfg[0]), .spr_upr(cfg[1]), .spr_cpucfgr(cfg[2]), .spr_dmmucfgr(cfg[3]),
        .spr_immucfgr(cfg[4]), .spr_dccfgr(cfg[5]), .spr_iccfgr(cfg[6]), .spr_dcfgr(cfg[7]),
        .spr_pccfgr(cfg[8]), .spr_vr2(cfg[9]), .spr_avr(cfg[10])
    );

    mor1kx_cfgrs_arbiter #(.FEATURE_DEBUGUNIT("NONE")) u_nodu (
        .clk(clk), .rst(rst),
        .cpu_spr_req_i(req[2]), .cpu_spr_addr_i(addr[2]), .cpu_spr_we_i(we[2]),
        .cpu_spr_ack_o(ack[2]), .cpu_spr_dat_o(dat[2]),
        .du_spr_req_i(req[3]), .du_spr_addr_i(addr[3]), .du_spr_we_i(we[3]),
        .du_spr_ack_o(ack[3]), .du_spr_dat_o(dat[3]),
        .spr_vr(cfg[0]), .spr_upr(cfg[1]), .spr_cpucfgr(cfg[2]), .spr_dmmucfgr(cfg[3]),
        .spr_immucfgr(cfg[4]), .spr_dccfgr(cfg[5]), .spr_iccfgr(cfg[6]), .spr_dcfgr(cfg[7]),
        .spr_pccfgr(cfg[8]), .spr_vr2(cfg[9]), .spr_avr(cfg[10])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [31:0] ref_data(input logic [15:0] a, input logic w);
        if (w || a[15:11] != 5'd0 || a[10:0] > 11'd10) return 32'h0;
        return cfg[a[3:0]];
    endfunction

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return {5'd0, 11'($urandom_range(0, 12))};
            2:       return {5'($urandom_range(1, 31)), 11'($urandom)};
            default: return 16'($urandom);
        endcase
    endfunction

    // Reference model: one access at a time per instance, each answered in the cycle after
    // its grant; contention goes to the side that did not win last time (DU after reset).
    always @(posedge clk) begin
        logic c, d;
        int   g;
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i]    = 1'b0;
                m_last_du[i] = 1'b1;
            end else if (m_busy[i]) begin
                m_busy[i] = 1'b0;
            end else begin
                c = req[2*i];
                d = req[2*i+1] && (i == 0);
                g = -1;
                if (c && d)  g = m_last_du[i] ? 0 : 1;
                else if (c)  g = 0;
                else if (d)  g = 1;
                if (g >= 0) begin
                    q[2*i+g].push_back('{due: cyc, data: ref_data(addr[2*i+g], we[2*i+g])});
                    m_busy[i]    = 1'b1;
                    m_last_du[i] = (g == 1);
                end
            end
        end
    end

    // Monitor: sampled mid-cycle, compares acks and data against the scoreboard.
    always @(negedge clk) begin
        logic e_ack;
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            e_ack = (q[p].size() > 0) && (q[p][0].due == cyc);
            check($sformatf("ack_p%0d", p), {31'b0, ack[p]}, {31'b0, e_ack});
            if (e_ack) begin
                e = q[p].pop_front();
                if (ack[p]) check($sformatf("dat_p%0d", p), dat[p], e.data);
            end else if (!ack[p]) begin
                check($sformatf("idle_dat_p%0d", p), dat[p], 32'h0);
            end
            if (p < 2 && ack[p]) begin
                log_port.push_back(p);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int p, input logic [15:0] a, input logic w,
                          input string nm, input logic [31:0] exp_dat);
        int n;
        n = 0;
        req[p] = 1'b1; addr[p] = a; we[p] = w;
        do begin
            tick();
            n++;
        end while (!ack[p] && n < 16);
        check({nm, "_lat"}, n, 1);
        check({nm, "_dat"}, dat[p], exp_dat);
        // Scramble inputs during the ack cycle; the captured request must still be used.
        addr[p] = 16'($urandom); we[p] = 1'($urandom);
        tick();
        req[p] = 1'b0;
    endtask

    initial begin
        bit        hold [4];
        int        c0;
        rst  = 1'b1;
        req  = '0;
        we   = '0;
        addr = '0;
        for (int i = 0; i <= 10; i++) cfg[i] = 32'hCF00_0000 | (i << 8) | i;
        cfg[2] = 32'h0000_0320;

        repeat (3) tick();
        for (int p = 0; p < 4; p++) begin
            check($sformatf("rst_ack_p%0d", p), {31'b0, ack[p]}, 32'h0);
            check($sformatf("rst_dat_p%0d", p), dat[p], 32'h0);
        end
        rst = 1'b0;
        req[3] = 1'b1;
        addr[3] = 16'h0002;
        tick();

        access(0, 16'h0002, 1'b0, "r027_cpucfgr", 32'h0000_0320);
        access(1, 16'h000B, 1'b0, "r029_du_idx11", 32'h0);
        access(0, 16'h0800, 1'b0, "r029_cpu_grp1", 32'h0);
        access(0, 16'h0001, 1'b1, "r030_write", 32'h0);
        access(0, 16'h0001, 1'b0, "r030_upr", cfg[1]);
        access(2, 16'h000A, 1'b0, "r032_avr", cfg[10]);
        tick();

        req[0] = 1'b1; addr[0] = 16'h0002; we[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("r031_no_ack_cpu", {31'b0, ack[0]}, 32'h0);
        check("r031_no_ack_du", {31'b0, ack[1]}, 32'h0);
        req[0] = 1'b0;
        rst = 1'b0;
        tick();
        access(0, 16'h0004, 1'b0, "r031_after", cfg[4]);
        tick();

        rst = 1'b1;
        req[0] = 1'b1; addr[0] = 16'h0005; we[0] = 1'b0;
        req[1] = 1'b1; addr[1] = 16'h0009; we[1] = 1'b0;
        tick(); tick();
        rst = 1'b0;
        c0 = cyc;
        log_port.delete();
        log_cyc.delete();
        repeat (8) tick();
        req[0] = 1'b0; req[1] = 1'b0;
        tick(); tick();
        check("r028_n_acks", log_port.size(), 4);
        for (int i = 0; i < 4 && i < log_port.size(); i++) begin
            check($sformatf("r028_order_%0d", i), log_port[i], i % 2);
            check($sformatf("r028_cycle_%0d", i), log_cyc[i], c0 + 1 + 2*i);
        end

        for (int p = 0; p < 4; p++) hold[p] = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (hold[p]) begin
                    hold[p] = 1'b0;
                    req[p]  = ($urandom_range(0, 2) == 0);
                    addr[p] = rand_addr();
                    we[p]   = ($urandom_range(0, 3) == 0);
                end else if (req[p] && ack[p]) begin
                    hold[p] = 1'b1;
                    addr[p] = 16'($urandom);
                    we[p]   = 1'($urandom);
                end else if (!req[p] && $urandom_range(0, 1) == 1) begin
                    req[p]  = 1'b1;
                    addr[p] = rand_addr();
                    we[p]   = ($urandom_range(0, 3) == 0);
                end
            end
            addr[3] = rand_addr();
            tick();
        end

        req = '0;
        repeat (4) tick();
        for (int p = 0; p < 4; p++) check($sformatf("drain_p%0d", p), q[p].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
